// File: rtl/ld_stream_q.sv
// Streaming line loader: issues credit-gated line reads to memory and buffers the
// in-order returns in a first-word-fall-through FIFO for the consumer.
module ld_stream_q #(
  parameter int DDR_DATA_WIDTH = 512,
  parameter int ADDR_WIDTH     = 32,
  parameter int DEPTH          = 8,
  parameter int LINE_BYTES     = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [15:0]               cmd_len,
  output logic                      ldq_ddr_addr_valid,
  input  logic                      ldq_ddr_addr_ready,
  output logic [ADDR_WIDTH-1:0]     ldq_ddr_addr,
  input  logic                      ldq_ddr_data_valid,
  input  logic [DDR_DATA_WIDTH-1:0] ldq_ddr_data,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [DDR_DATA_WIDTH-1:0] rd_data,
  output logic                      rd_last,
  output logic                      busy,
  output logic                      done,
  output logic                      ovf_err,
  output logic [1:0]                dbg_state
);
  // Handshakes: a valid/ready transfer happens on a rising edge where both are 1;
  // while valid=1 and ready=0 the source holds valid and payload unchanged.
  // ldq_ddr_data_valid has no ready: every asserted cycle is one returned line.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     base_q, base_d, addr_q, addr_d;
  logic [15:0]               len_q, len_d, issued_q, issued_d, popped_q, popped_d;
  logic [CW-1:0]             inflight_q, inflight_d, count_q, count_d;
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                      addr_valid_q, addr_valid_d, done_q, done_d, ovf_q, ovf_d;
  logic [DDR_DATA_WIDTH-1:0] mem [DEPTH];

  logic                      accept, start, issue_hs, ret_ok, wr_en, pop, full, room;
  logic [CW:0]               occ_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ISSUE;
      S_ISSUE: if (issue_hs && (issued_d == len_q)) state_d = S_DRAIN;
      S_DRAIN: if (pop && (popped_d == len_q)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    accept     = (state_q == S_IDLE) && cmd_valid;
    start      = accept && (cmd_len != 16'd0);
    issue_hs   = addr_valid_q && ldq_ddr_addr_ready;
    full       = (count_q == CW'(DEPTH));
    ret_ok     = ldq_ddr_data_valid && (inflight_q != '0);
    wr_en      = ret_ok && !full;
    pop        = (count_q != '0) && rd_ready;
    base_d     = start ? cmd_addr : base_q;
    len_d      = start ? cmd_len : len_q;
    issued_d   = start ? 16'd0 : issued_q + {15'd0, issue_hs};
    popped_d   = start ? 16'd0 : popped_q + {15'd0, pop};
    inflight_d = inflight_q + CW'(issue_hs) - CW'(ret_ok);
    count_d    = count_q + CW'(wr_en) - CW'(pop);
    wr_ptr_d   = wr_ptr_q + PW'(wr_en);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    // Occupancy after this edge; a new request is only raised if it will have a slot.
    occ_d      = {1'b0, inflight_d} + {1'b0, count_d};
    room       = occ_d < (CW + 1)'(DEPTH);
    ovf_d      = ovf_q | (ldq_ddr_data_valid && ((inflight_q == '0) || full));
    done_d     = (accept && (cmd_len == 16'd0)) ||
                 ((state_q == S_DRAIN) && pop && (popped_d == len_q));
    addr_valid_d = 1'b0;
    addr_d       = addr_q;
    if (addr_valid_q && !ldq_ddr_addr_ready) begin
      addr_valid_d = 1'b1;
    end else if ((state_q == S_ISSUE) && (issued_d != len_q) && room) begin
      addr_valid_d = 1'b1;
      addr_d       = base_q + ADDR_WIDTH'(issued_d) * ADDR_WIDTH'(LINE_BYTES);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q       <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      issued_q     <= '0;
      popped_q     <= '0;
      inflight_q   <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      addr_valid_q <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      base_q       <= base_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      issued_q     <= issued_d;
      popped_q     <= popped_d;
      inflight_q   <= inflight_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      addr_valid_q <= addr_valid_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= ldq_ddr_data;
  end

  always_comb begin
    cmd_ready          = (state_q == S_IDLE);
    busy               = (state_q != S_IDLE);
    dbg_state          = state_q;
    ldq_ddr_addr_valid = addr_valid_q;
    ldq_ddr_addr       = addr_q;
    rd_valid           = (count_q != '0);
    rd_data            = rd_valid ? mem[rd_ptr_q] : '0;
    rd_last            = rd_valid && (popped_q == len_q - 16'd1);
    done               = done_q;
    ovf_err            = ovf_q;
  end
endmodule

// File: tb/tb_ld_stream_q.sv
// Bench for ld_stream_q: a latency-configurable memory model answers line requests
// and a scoreboard checks every popped line and its last flag in order.
module tb_ld_stream_q;
  localparam int DW = 512;
  localparam int AW = 32;
  localparam int LB = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [15:0]   cmd_len;
  logic          ldq_ddr_addr_valid, ldq_ddr_addr_ready;
  logic [AW-1:0] ldq_ddr_addr;
  logic          ldq_ddr_data_valid;
  logic [DW-1:0] ldq_ddr_data;
  logic          rd_valid, rd_ready, rd_last;
  logic [DW-1:0] rd_data;
  logic          busy, done, ovf_err;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  ld_stream_q #(.DDR_DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(8), .LINE_BYTES(LB)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .ldq_ddr_addr_valid(ldq_ddr_addr_valid), .ldq_ddr_addr_ready(ldq_ddr_addr_ready),
    .ldq_ddr_addr(ldq_ddr_addr), .ldq_ddr_data_valid(ldq_ddr_data_valid),
    .ldq_ddr_data(ldq_ddr_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_last(rd_last), .busy(busy), .done(done),
    .ovf_err(ovf_err), .dbg_state(dbg_state)
  );

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] resp_d[$];
  int            resp_t[$];
  logic [AW-1:0] req_addr[$];
  int            req_cyc[$];
  int            lat = 2;
  logic          addr_rdy_g = 1'b1;
  logic          rd_rdy_g = 1'b1;
  int            pop_idx = 0;
  int            cur_len = 0;
  int            done_cnt = 0;
  logic [AW-1:0] cur_base = '0;

  function automatic logic [DW-1:0] line_of(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    for (int i = 0; i < DW / AW; i++) v[i*AW +: AW] = a + AW'(i * 7);
    return v;
  endfunction

  // One cycle: observe at the falling edge, then set inputs for the next rising edge.
  task automatic tick();
    logic [DW-1:0] exp;
    logic          exp_last;
    @(negedge clk);
    cyc++;
    if (done) done_cnt++;
    if (resp_t.size() > 0 && resp_t[0] <= cyc) begin
      ldq_ddr_data_valid = 1'b1;
      ldq_ddr_data       = resp_d.pop_front();
      void'(resp_t.pop_front());
    end else begin
      ldq_ddr_data_valid = 1'b0;
      ldq_ddr_data       = '0;
    end
    ldq_ddr_addr_ready = addr_rdy_g;
    rd_ready           = rd_rdy_g;
    if (!rst && ldq_ddr_addr_valid && ldq_ddr_addr_ready) begin
      exp_q.push_back(line_of(cur_base + AW'(req_addr.size() * LB)));
      req_addr.push_back(ldq_ddr_addr);
      req_cyc.push_back(cyc);
      resp_t.push_back(cyc + lat);
      resp_d.push_back(line_of(ldq_ddr_addr));
    end
    if (!rst && rd_valid && rd_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow: popped %h with no expected line", rd_data);
      end else begin
        exp = exp_q.pop_front();
        if (rd_data !== exp) begin
          failures++;
          $display("FAIL sb_data[%0d]: got %h expected %h", pop_idx, rd_data, exp);
        end
      end
      checks++;
      exp_last = (pop_idx == cur_len - 1);
      if (rd_last !== exp_last) begin
        failures++;
        $display("FAIL sb_last[%0d]: got %b expected %b", pop_idx, rd_last, exp_last);
      end
      pop_idx++;
    end
  endtask

  task automatic issue_cmd(input logic [AW-1:0] a, input logic [15:0] l);
    req_addr.delete();
    req_cyc.delete();
    pop_idx  = 0;
    done_cnt = 0;
    cur_len  = int'(l);
    cur_base = a;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string tag);
    int n = 0;
    while (done_cnt == 0 && n < bound) begin
      tick();
      n++;
    end
    checks++;
    if (done_cnt == 0) begin
      failures++;
      $display("FAIL %s_timeout: no done within %0d cycles", tag, bound);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (cmd_ready !== 1'b1 || ldq_ddr_addr_valid !== 1'b0 || rd_valid !== 1'b0 ||
        rd_last !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || ovf_err !== 1'b0 ||
        dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_ctrl: rdy=%b av=%b rv=%b last=%b done=%b busy=%b ovf=%b st=%0d expected 1,0,0,0,0,0,0,0",
               cmd_ready, ldq_ddr_addr_valid, rd_valid, rd_last, done, busy, ovf_err, dbg_state);
    end
    checks++;
    if (ldq_ddr_addr !== '0 || rd_data !== '0) begin
      failures++;
      $display("FAIL reset_data: addr=%h rd_data=%h expected zeros", ldq_ddr_addr, rd_data);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: cmd_ready=%b busy=%b expected 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_basic_stream();
    lat = 2; addr_rdy_g = 1'b1; rd_rdy_g = 1'b1;
    issue_cmd(32'h1000, 16'd4);
    wait_done(100, "basic");
    repeat (4) tick();
    checks++;
    if (req_addr.size() != 4) begin
      failures++;
      $display("FAIL basic_req_count: got %0d expected 4", req_addr.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < req_addr.size()) begin
        checks++;
        if (req_addr[i] !== 32'h1000 + 32'(i * LB)) begin
          failures++;
          $display("FAIL basic_addr[%0d]: got %h expected %h", i, req_addr[i], 32'h1000 + 32'(i * LB));
        end
        checks++;
        if (req_cyc[i] != req_cyc[0] + i) begin
          failures++;
          $display("FAIL basic_b2b[%0d]: cycle %0d expected %0d", i, req_cyc[i], req_cyc[0] + i);
        end
      end
    end
    checks++;
    if (done_cnt != 1 || pop_idx != 4 || exp_q.size() != 0 || ovf_err !== 1'b0) begin
      failures++;
      $display("FAIL basic_end: done=%0d pops=%0d left=%0d ovf=%b expected 1 4 0 0",
               done_cnt, pop_idx, exp_q.size(), ovf_err);
    end
  endtask

  task automatic test_credit_limit();
    lat = 2; addr_rdy_g = 1'b1; rd_rdy_g = 1'b0;
    issue_cmd(32'h8000, 16'd20);
    repeat (40) tick();
    checks++;
    if (req_addr.size() != 8 || ldq_ddr_addr_valid !== 1'b0) begin
      failures++;
      $display("FAIL credit_stall: reqs=%0d valid=%b expected 8 0", req_addr.size(), ldq_ddr_addr_valid);
    end
    checks++;
    if (rd_valid !== 1'b1 || busy !== 1'b1 || dbg_state !== 2'd1) begin
      failures++;
      $display("FAIL credit_state: rd_valid=%b busy=%b st=%0d expected 1 1 1", rd_valid, busy, dbg_state);
    end
    rd_rdy_g = 1'b1;
    wait_done(400, "credit");
    repeat (3) tick();
    checks++;
    if (req_addr.size() != 20 || pop_idx != 20 || done_cnt != 1 || ovf_err !== 1'b0) begin
      failures++;
      $display("FAIL credit_end: reqs=%0d pops=%0d done=%0d ovf=%b expected 20 20 1 0",
               req_addr.size(), pop_idx, done_cnt, ovf_err);
    end
  endtask

  task automatic test_addr_stall();
    logic [AW-1:0] held;
    int n = 0;
    lat = 3; addr_rdy_g = 1'b0; rd_rdy_g = 1'b1;
    issue_cmd(32'h2000, 16'd2);
    while (!ldq_ddr_addr_valid && n < 10) begin
      tick();
      n++;
    end
    held = ldq_ddr_addr;
    checks++;
    if (ldq_ddr_addr_valid !== 1'b1 || held !== 32'h2000) begin
      failures++;
      $display("FAIL stall_first: valid=%b addr=%h expected 1 00002000", ldq_ddr_addr_valid, held);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ldq_ddr_addr_valid !== 1'b1 || ldq_ddr_addr !== 32'h2000) begin
        failures++;
        $display("FAIL stall_hold[%0d]: valid=%b addr=%h expected 1 00002000", i, ldq_ddr_addr_valid, ldq_ddr_addr);
      end
    end
    addr_rdy_g = 1'b1;
    tick();
    checks++;
    if (req_addr.size() != 1) begin
      failures++;
      $display("FAIL stall_release: reqs=%0d expected 1", req_addr.size());
    end
    wait_done(100, "stall");
    repeat (2) tick();
    checks++;
    if (req_addr.size() != 2 || (req_addr.size() == 2 && req_addr[1] !== 32'h2040)) begin
      failures++;
      $display("FAIL stall_end: reqs=%0d expected 2 with second 00002040", req_addr.size());
    end
  endtask

  task automatic test_zero_len();
    lat = 2; addr_rdy_g = 1'b1; rd_rdy_g = 1'b1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL zero_ready: cmd_ready=%b expected 1", cmd_ready);
    end
    issue_cmd(32'h5000, 16'd0);
    checks++;
    if (done !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_done: done=%b cmd_ready=%b busy=%b expected 1 1 0", done, cmd_ready, busy);
    end
    repeat (5) tick();
    checks++;
    if (done_cnt != 1 || req_addr.size() != 0 || ldq_ddr_addr_valid !== 1'b0) begin
      failures++;
      $display("FAIL zero_end: done pulses=%0d reqs=%0d valid=%b expected 1 0 0",
               done_cnt, req_addr.size(), ldq_ddr_addr_valid);
    end
  endtask

  task automatic test_addr_wrap();
    lat = 2; addr_rdy_g = 1'b1; rd_rdy_g = 1'b1;
    issue_cmd(32'hFFFF_FFC0, 16'd2);
    wait_done(100, "wrap");
    repeat (2) tick();
    checks++;
    if (req_addr.size() != 2) begin
      failures++;
      $display("FAIL wrap_count: reqs=%0d expected 2", req_addr.size());
    end else begin
      checks++;
      if (req_addr[0] !== 32'hFFFF_FFC0 || req_addr[1] !== 32'h0000_0000) begin
        failures++;
        $display("FAIL wrap_addr: got %h %h expected ffffffc0 00000000", req_addr[0], req_addr[1]);
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    int n = 0;
    lat = 30; addr_rdy_g = 1'b1; rd_rdy_g = 1'b1;
    issue_cmd(32'h3000, 16'd8);
    while (req_addr.size() < 3 && n < 20) begin
      tick();
      n++;
    end
    addr_rdy_g = 1'b0;
    tick();
    checks++;
    if (req_addr.size() != 3 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_setup: reqs=%0d busy=%b expected 3 1", req_addr.size(), busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ldq_ddr_addr_valid !== 1'b0 || busy !== 1'b0 || rd_valid !== 1'b0 ||
        cmd_ready !== 1'b1 || ldq_ddr_addr !== '0) begin
      failures++;
      $display("FAIL rstmid_async: valid=%b busy=%b rv=%b rdy=%b addr=%h expected 0 0 0 1 0",
               ldq_ddr_addr_valid, busy, rd_valid, cmd_ready, ldq_ddr_addr);
    end
    resp_t.delete();
    resp_d.delete();
    exp_q.delete();
    tick();
    rst = 1'b0;
    addr_rdy_g = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      resp_t.push_back(cyc + i);
      resp_d.push_back(line_of(32'h3000 + 32'(i * LB)));
    end
    tick();
    checks++;
    if (ovf_err !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_pre: ovf_err=%b expected 0", ovf_err);
    end
    tick();
    checks++;
    if (ovf_err !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_ovf: ovf_err=%b expected 1", ovf_err);
    end
    repeat (3) tick();
    checks++;
    if (rd_valid !== 1'b0 || busy !== 1'b0 || ldq_ddr_addr_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_idle: rv=%b busy=%b av=%b expected 0 0 0", rd_valid, busy, ldq_ddr_addr_valid);
    end
    lat = 2;
    issue_cmd(32'h4000, 16'd3);
    wait_done(100, "rstmid");
    repeat (2) tick();
    checks++;
    if (req_addr.size() != 3 || pop_idx != 3 || ovf_err !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_new: reqs=%0d pops=%0d ovf=%b expected 3 3 1", req_addr.size(), pop_idx, ovf_err);
    end
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    ldq_ddr_addr_ready = 1'b0; ldq_ddr_data_valid = 1'b0; ldq_ddr_data = '0;
    rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic_stream();
    test_credit_limit();
    test_addr_stall();
    test_zero_len();
    test_addr_wrap();
    test_reset_mid_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ld_stream_q.md
LD_STREAM_Q -- requirements
Module: ld_stream_q

Interface
REQ-001 Parameters (name, default, meaning): DDR_DATA_WIDTH, 512, line width in bits; ADDR_WIDTH, 32, byte address width; DEPTH, 8, return-buffer entries (power of 2, 2..64); LINE_BYTES, 64, address stride per line.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock.
- rst, in, 1, asynchronous active-high reset.
- cmd_valid, in, 1, stream command offered.
- cmd_ready, out, 1, command accepted.
- cmd_addr, in, ADDR_WIDTH, first line byte address.
- cmd_len, in, 16, number of lines.
- ldq_ddr_addr_valid, out, 1, line read request to memory arbiter.
- ldq_ddr_addr_ready, in, 1, request accepted.
- ldq_ddr_addr, out, ADDR_WIDTH, request address.
- ldq_ddr_data_valid, in, 1, one returned line; no backpressure.
- ldq_ddr_data, in, DDR_DATA_WIDTH, returned line.
- rd_valid, out, 1, buffered line available.
- rd_ready, in, 1, consumer takes line.
- rd_data, out, DDR_DATA_WIDTH, line data.
- rd_last, out, 1, final line of command.
- busy, out, 1, command in progress.
- done, out, 1, one-cycle pulse on completion.
- ovf_err, out, 1, sticky return-buffer overflow flag.

Function
REQ-003 FSM states: IDLE, ISSUE, DRAIN; cmd_ready SHALL equal (state==IDLE).
REQ-004 IDLE, cmd_valid=1, cmd_len!=0 -> latch addr and len, zero the issue and pop counters, enter ISSUE next cycle.
REQ-005 IDLE, cmd_valid=1, cmd_len=0 -> accept, stay IDLE, pulse done next cycle, no memory request.
REQ-006 In ISSUE, ldq_ddr_addr SHALL be cmd_addr + issued*LINE_BYTES, computed modulo 2^ADDR_WIDTH (wraps, no error).
REQ-007 ldq_ddr_addr_valid SHALL be registered: asserted in ISSUE only when credit>0, where credit = DEPTH - (inflight + fifo_count).
REQ-008 Once ldq_ddr_addr_valid is asserted, it and ldq_ddr_addr SHALL stay stable until sampled with ldq_ddr_addr_ready=1.
REQ-009 Each valid&ready cycle: issued+1, inflight+1; the next address is presented on the following cycle if credit permits (back-to-back issue allowed).
REQ-010 When issued==len after a handshake, ldq_ddr_addr_valid SHALL deassert the next cycle and FSM SHALL enter DRAIN.
REQ-011 Each ldq_ddr_data_valid cycle: write ldq_ddr_data to the FIFO tail, inflight-1; data is in-order, so no tagging.
REQ-012 Issue handshake and data return in the same cycle: inflight unchanged.
REQ-013 Write and pop in the same cycle: fifo_count unchanged; a write to an empty FIFO becomes visible on rd_valid the next cycle.
REQ-014 FIFO output is first-word-fall-through: rd_data/rd_valid come from the head register; pop on rd_valid&rd_ready.
REQ-015 rd_last SHALL be 1 when rd_valid=1 and popped==len-1.
REQ-016 ldq_ddr_data_valid while FIFO full: drop the data, set ovf_err; only reset clears it.
REQ-017 DRAIN: on the pop where popped reaches len, go to IDLE and pulse done the next cycle.
REQ-018 busy = (state!=IDLE).
REQ-019 ldq_ddr_data_valid with inflight==0: set ovf_err, discard the data.
REQ-020 Max memory latency is unbounded; credit gating alone guarantees no overflow.

Reset
REQ-021 rst=1 asynchronously SHALL force: state=IDLE; counters, inflight, FIFO pointers = 0; ldq_ddr_addr_valid=0, rd_valid=0, rd_last=0, done=0, busy=0, ovf_err=0; cmd_ready=1 after release.
REQ-022 Reset mid-command SHALL abandon all state; late ldq_ddr_data_valid after reset release SHALL set ovf_err (REQ-019).
REQ-023 Data outputs (ldq_ddr_addr, rd_data) SHALL be 0 after reset.

Verification
REQ-024 addr=0x1000, len=4, ready always 1, data returned 2 cycles after each request, rd_ready=1 -> addresses 0x1000, 0x1040, 0x1080, 0x10C0 on consecutive cycles; 4 lines out in order; rd_last on the 4th; done pulses once.
REQ-025 DEPTH=8, len=20, rd_ready=0 -> exactly 8 requests, then ldq_ddr_addr_valid=0; after rd_ready=1, issue resumes; total 20 requests; ovf_err=0.
REQ-026 ldq_ddr_addr_ready held 0 for 5 cycles -> ldq_ddr_addr and valid stable for all 5 cycles; a single handshake on release.
REQ-027 len=0 -> cmd_ready=1, no requests, done pulse 1 cycle after accept.
REQ-028 addr=0xFFFFFFC0, len=2 -> addresses 0xFFFFFFC0, 0x00000000.
REQ-029 rst asserted mid-stream with 3 inflight, 3 data beats injected after release -> outputs idle, ovf_err=1 after the first beat, new command accepted.
